// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared constants and types for the burst memory responder
package burst_mem_pkg;
  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] line;
    logic [7:0]        ts;
  } rd_req_t;

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, BEAT3} beat_state_e;
endpackage

// File: rtl/burst_mem_req_fifo.sv
// burst_mem_req_fifo: in-order queue of snapshotted read requests awaiting their beats
module burst_mem_req_fifo
  import burst_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  rd_req_t                din_i,
  input  logic                   pop_i,
  output rd_req_t                head_o,
  output logic [7:0]             next_ts_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  rd_req_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q, rp1;
  logic [AW:0] cnt_q;
  assign rp1       = rp_q + 1'b1;
  assign head_o    = mem_q[rp_q];
  assign next_ts_o = mem_q[rp1].ts;
  assign count_o   = cnt_q;
  assign full_o    = cnt_q == (AW+1)'(DEPTH);
  assign empty_o   = cnt_q == '0;
  // pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  // payload storage needs no reset: only slots behind valid pointers are read
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-granular DRAM stand-in with pipelined fixed-latency 4-beat read bursts
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LINES   = 256,
  parameter int LATENCY = 8,
  parameter int QDEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dram_addr,
  input  logic              dram_read,
  input  logic              dram_write,
  input  logic [BEAT_W-1:0] dram_wdata,
  output logic              dram_ready,
  output logic [31:0]       dram_raddr,
  output logic [BEAT_W-1:0] dram_rdata,
  output logic              dram_rvalid,
  output logic              dram_err
);
  localparam int IW = $clog2(LINES);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [LINE_W-1:0] mem [LINES];
  logic [IW-1:0] idx, wr_idx_q, wr_idx_d;
  logic [7:0] ts_q, next_ts;
  logic ready_q, ready_d, err_q, err_d, wr_busy_q, wr_busy_d;
  logic [1:0] wr_cnt_q, wr_cnt_d, beat;
  logic [3*BEAT_W-1:0] wr_buf_q, wr_buf_d;
  logic commit, push, pop, full, empty, full_d, head_due, next_due, unused_lsb;
  logic [CW-1:0] count;
  rd_req_t din, head;
  beat_state_e st_q, st_d;

  assign idx        = dram_addr[OFFSET_BITS +: IW];
  assign unused_lsb = ^dram_addr[OFFSET_BITS-1:0];
  assign din        = '{addr: {dram_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}}, line: mem[idx], ts: ts_q};

  burst_mem_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .din_i    (din),
    .pop_i    (pop),
    .head_o   (head),
    .next_ts_o(next_ts),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign head_due    = !empty && (ts_q - head.ts) >= 8'(LATENCY);
  assign next_due    = count >= CW'(2) && (ts_q - next_ts) >= 8'(LATENCY);
  assign full_d      = full ? !pop : (count == CW'(QDEPTH-1)) && push && !pop;
  assign ready_d     = !wr_busy_d && !full_d;
  assign dram_ready  = ready_q;
  assign dram_err    = err_q;
  assign beat        = st_q == BEAT1 ? 2'd1 : st_q == BEAT2 ? 2'd2 : st_q == BEAT3 ? 2'd3 : 2'd0;
  assign dram_rvalid = st_q != IDLE;
  assign dram_rdata  = dram_rvalid ? head.line[beat*BEAT_W +: BEAT_W] : '0;
  assign dram_raddr  = dram_rvalid ? head.addr : '0;

  // command acceptance and write-beat collection; a dropped beat aborts the write
  always_comb begin
    wr_busy_d = wr_busy_q;
    wr_cnt_d  = wr_cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_buf_d  = wr_buf_q;
    err_d     = err_q;
    commit    = 1'b0;
    push      = 1'b0;
    if (wr_busy_q) begin
      if (!dram_write) begin
        err_d     = 1'b1;
        wr_busy_d = 1'b0;
      end else if (wr_cnt_q == 2'd3) begin
        commit    = 1'b1;
        wr_busy_d = 1'b0;
      end else begin
        wr_buf_d[wr_cnt_q*BEAT_W +: BEAT_W] = dram_wdata;
        wr_cnt_d = wr_cnt_q + 2'd1;
      end
    end else if (ready_q) begin
      if (dram_read && dram_write) err_d = 1'b1;
      else if (dram_read) push = 1'b1;
      else if (dram_write) begin
        wr_busy_d           = 1'b1;
        wr_cnt_d            = 2'd1;
        wr_idx_d            = idx;
        wr_buf_d[BEAT_W-1:0] = dram_wdata;
      end
    end
  end

  // control registers and the free-running timestamp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q      <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_busy_q <= 1'b0;
      wr_cnt_q  <= '0;
      wr_idx_q  <= '0;
      wr_buf_q  <= '0;
    end else begin
      ts_q      <= ts_q + 8'd1;
      ready_q   <= ready_d;
      err_q     <= err_d;
      wr_busy_q <= wr_busy_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_buf_q  <= wr_buf_d;
    end
  end

  // the last beat arrives with the commit, so the full line is written in one go
  always_ff @(posedge clk) begin
    if (commit) mem[wr_idx_q] <= {dram_wdata, wr_buf_q};
  end

  // beat engine: start when the head is due, chain straight into the next due entry
  always_comb begin
    st_d = st_q;
    pop  = 1'b0;
    case (st_q)
      IDLE:  st_d = head_due ? BEAT0 : IDLE;
      BEAT0: st_d = BEAT1;
      BEAT1: st_d = BEAT2;
      BEAT2: st_d = BEAT3;
      BEAT3: begin
        pop  = 1'b1;
        st_d = next_due ? BEAT0 : IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // beat engine state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IDLE;
    else st_q <= st_d;
  end
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Synthesizable memory-side responder for the cache adapter's 64-bit DRAM burst interface.
- Accepts line reads and 4-beat line writes, and returns read data as 4-beat bursts tagged with the line address, after a fixed latency.
- Reads are pipelined: multiple can be outstanding, and they complete in command order.
- Serves as the backing store for cache subsystem benches and FPGA bring-up in place of external DRAM.

Parameters:
- LINES, 256, number of 256-bit lines stored (power of 2).
- LATENCY, 8, cycles from read acceptance to first data beat (1..200).
- QDEPTH, 4, maximum outstanding accepted reads (power of 2, >=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- dram_addr  input  32  command address (line-aligned; bits [4:0] ignored).
- dram_read  input  1  read command request.
- dram_write  input  1  write command / write beat valid.
- dram_wdata  input  64  write beat data.
- dram_ready  output  1  responder accepts a command this cycle.
- dram_raddr  output  32  line address of the current read beat ({addr[31:5],5'b0}).
- dram_rdata  output  64  read beat data.
- dram_rvalid  output  1  read beat valid.
- dram_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, async): dram_ready=0, dram_rvalid=0, dram_raddr=0, dram_rdata=0, dram_err=0; FIFO flushed; beat engine idle; write capture discarded (array unchanged); timestamp counter=0.
- Storage array is not reset; contents persist across reset.
- First cycle after reset release: dram_ready=1.
- Index = addr[5+log2(LINES)-1:5]; upper bits alias.
- dram_ready = !wr_busy && !fifo_full (registered).
- Read acceptance (dram_read && dram_ready at edge T): the full 256-bit line is snapshotted from the array into a FIFO entry {addr, line, ts=T}. The snapshot gives command-order consistency with earlier writes.
- Write acceptance (dram_write && dram_ready at edge T): beat0 is captured and wr_busy is set.
  - Beats 1..3 are sampled at T+1..T+3 with dram_write=1; addr is ignored after beat 0.
  - The line commits to the array at edge T+3; wr_busy clears and dram_ready=1 again at T+4.
  - If dram_write=0 during beats 1..3: set dram_err, discard the write, return to idle.
- dram_read && dram_write both 1 while dram_ready=1: nothing accepted; dram_err set.
- Commands while dram_ready=0 are ignored (no error).
- Beat engine: states IDLE, BEAT0..BEAT3.
  - IDLE -> BEAT0 when the FIFO is non-empty and (now - head.ts) >= LATENCY, using 8-bit wrap-around subtraction.
  - BEATk drives dram_rvalid=1 with dram_rdata=line[64k+63:64k] (beat 0 = bits 63:0).
  - BEAT3 pops the head, then goes to BEAT0 if the next entry is also due, else IDLE.
- Timing guarantees:
  - Read accepted at T gives beats at cycles T+L..T+L+3.
  - Back-to-back reads at T and T+1 are gapless: second read's beats at T+L+4..T+L+7.
- A read accepted while the engine is busy still has its entry stamped at acceptance.
- FIFO full (QDEPTH entries) drops dram_ready; the pop in BEAT3 frees a slot, and dram_ready=1 the next cycle.
- A read accepted at the edge where wr_busy clears cannot occur, because ready=0 until T+4.
- Timestamp counter is 8-bit free-running; LATENCY<=200 guarantees no aliasing with QDEPTH<=16.

Decomposition:
- Shared package burst_mem_pkg:
  - constants: BEATS=4, BEAT_W=64, LINE_W=256, OFFSET_BITS=5.
  - typedefs: rd_req_t {addr[31:0], line[255:0], ts[7:0]} and beat_state_e.
- Sub-module: burst_mem_req_fifo, a parameterized synchronous FIFO of rd_req_t with full/empty, async active-low reset.

Test Plan:
- Write line 0x00000100 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x100 -> dram_rvalid for 4 cycles starting exactly LATENCY=8 cycles after acceptance; raddr=0x100; data in order 0x11..,0x22..,0x33..,0x44...
- 4 reads on consecutive cycles (0x000,0x020,0x040,0x060) -> 16 contiguous rvalid beats, raddr stepping per 4 beats; the 5th read stalls with dram_ready=0 until the first BEAT3.
- Read 0x200 accepted, then write 0x200 with new data before the read's beats -> read returns the old data; a later read returns the new data.
- Write burst with dram_write dropped at beat 2 -> dram_err=1 (sticky), array at that line unchanged, dram_ready=1 the next cycle.
- dram_read=dram_write=1 simultaneously -> no acceptance, dram_err=1, no rvalid.
- rst=0 asserted mid-read-burst (after beat 1) -> rvalid=0 immediately; after release, dram_ready=1, FIFO empty, no stale beats; earlier-written data still readable.
